// File: rtl/sockit_spi_rdb.sv
`default_nettype none
// ============================================================================
// Module   : sockit_spi_rdb
// Purpose  : Read data buffer. FWFT FIFO of {ctl,dat} command words with
//            req/grt handshakes on both sides. Optional last-segment
//            interrupt built when SOCKIT_SPI_RDB_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sockit_spi_rdb #(
  parameter int CCI   = 4,
  parameter int CDW   = 32,
  parameter int DEPTH = 4,
  parameter int DPL   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           cmd_req,
  input  logic [CCI-1:0] cmd_ctl,
  input  logic [CDW-1:0] cmd_dat,
  output logic           cmd_grt,
  output logic           bus_req,
  output logic [CCI-1:0] bus_ctl,
  output logic [CDW-1:0] bus_dat,
  input  logic           bus_grt,
  output logic [DPL:0]   sts_cnt,
  output logic           irq
);

  localparam logic [DPL:0] C_FULL = (DPL+1)'(DEPTH);

  logic [CCI+CDW-1:0] r_mem [DEPTH];
  logic [DPL-1:0]     r_wr_ptr;
  logic [DPL-1:0]     r_rd_ptr;
  logic [DPL:0]       r_cnt;
  logic               w_wr;
  logic               w_rd;

  // Flags come from the registered count only, so cmd_grt never sees cmd_req.
  assign cmd_grt = (r_cnt != C_FULL);
  assign bus_req = (r_cnt != '0);
  assign sts_cnt = r_cnt;
  assign w_wr    = cmd_req & cmd_grt;
  assign w_rd    = bus_req & bus_grt;

  assign {bus_ctl, bus_dat} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr && !clr) begin
      r_mem[r_wr_ptr] <= {cmd_ctl, cmd_dat};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_rd)      r_cnt <= r_cnt + 1'b1;
      else if (!w_wr && w_rd) r_cnt <= r_cnt - 1'b1;
    end
  end

`ifdef SOCKIT_SPI_RDB_IRQ_EN
  logic [DPL:0] r_lst_cnt;
  logic         r_irq;
  logic         w_lst_wr;
  logic         w_lst_rd;

  // Counts buffered words flagged as last segment (ctl bit 2).
  assign w_lst_wr = w_wr & cmd_ctl[2];
  assign w_lst_rd = w_rd & bus_ctl[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lst_cnt <= '0;
      r_irq     <= 1'b0;
    end else if (clr) begin
      r_lst_cnt <= '0;
      r_irq     <= 1'b0;
    end else begin
      if (w_lst_wr && !w_lst_rd)      r_lst_cnt <= r_lst_cnt + 1'b1;
      else if (!w_lst_wr && w_lst_rd) r_lst_cnt <= r_lst_cnt - 1'b1;
      r_irq <= (r_lst_cnt != '0);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sockit_spi_rdb.sv
`default_nettype none
// ============================================================================
// Module   : tb_sockit_spi_rdb
// Purpose  : Randomized and directed bench for sockit_spi_rdb against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sockit_spi_rdb;

  localparam int DEPTH = 4;
`ifdef SOCKIT_SPI_RDB_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        cmd_req = 1'b0;
  logic [3:0]  cmd_ctl = '0;
  logic [31:0] cmd_dat = '0;
  logic        cmd_grt;
  logic        bus_req;
  logic [3:0]  bus_ctl;
  logic [31:0] bus_dat;
  logic        bus_grt = 1'b0;
  logic [2:0]  sts_cnt;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [35:0] mq[$];
  logic        irq_m = 1'b0;

  sockit_spi_rdb #(.CCI(4), .CDW(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .cmd_req(cmd_req), .cmd_ctl(cmd_ctl), .cmd_dat(cmd_dat), .cmd_grt(cmd_grt),
    .bus_req(bus_req), .bus_ctl(bus_ctl), .bus_dat(bus_dat), .bus_grt(bus_grt),
    .sts_cnt(sts_cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int lst_in_queue();
    int n = 0;
    foreach (mq[i]) if (mq[i][34]) n++;
    return n;
  endfunction

  task automatic compare();
    check("cmd_grt", 64'(cmd_grt), 64'(mq.size() != DEPTH));
    check("bus_req", 64'(bus_req), 64'(mq.size() != 0));
    check("sts_cnt", 64'(sts_cnt), 64'(mq.size()));
    check("irq", 64'(irq), 64'(irq_m));
    if (mq.size() != 0) begin
      check("bus_ctl", 64'(bus_ctl), 64'(mq[0][35:32]));
      check("bus_dat", 64'(bus_dat), 64'(mq[0][31:0]));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic cr, input logic [3:0] ctl, input logic [31:0] dat,
                      input logic bg, input logic cl);
    bit wr, rd;
    int lst;
    cmd_req = cr; cmd_ctl = ctl; cmd_dat = dat; bus_grt = bg; clr = cl;
    wr  = cr && (mq.size() != DEPTH);
    rd  = bg && (mq.size() != 0);
    lst = lst_in_queue();
    @(posedge clk);
    if (cl) begin
      mq.delete();
      irq_m = 1'b0;
    end else begin
      irq_m = IRQ_EN && (lst != 0);
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back({ctl, dat});
    end
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compare();
    check("rst_grt", 64'(cmd_grt), 64'd1);
    check("rst_cnt", 64'(sts_cnt), 64'd0);

    // Single word, FWFT latency of one cycle
    step(1'b1, 4'h1, 32'hA5A5_0001, 1'b0, 1'b0);
    check("first_dat", 64'(bus_dat), 64'hA5A5_0001);
    check("first_ctl", 64'(bus_ctl), 64'h1);
    check("first_cnt", 64'(sts_cnt), 64'd1);
    step(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);

    // Overfill: five offered, four taken
    for (int i = 0; i < 5; i++) step(1'b1, 4'(i), 32'h1000 + 32'(i), 1'b0, 1'b0);
    check("full_cnt", 64'(sts_cnt), 64'd4);
    check("full_grt", 64'(cmd_grt), 64'd0);
    step(1'b1, 4'h4, 32'h1004, 1'b1, 1'b0);
    check("reopen_grt", 64'(cmd_grt), 64'd1);
    check("reopen_cnt", 64'(sts_cnt), 64'd3);
    step(1'b1, 4'h4, 32'h1004, 1'b0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      check("order", 64'(bus_dat), 64'h1000 + 64'(i));
      step(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    end

    // Streaming: count must hold at one while pointers wrap
    step(1'b1, 4'h2, 32'h2000, 1'b0, 1'b0);
    for (int i = 1; i <= 2*DEPTH+3; i++) begin
      step(1'b1, 4'h2, 32'h2000 + 32'(i), 1'b1, 1'b0);
      check("stream_cnt", 64'(sts_cnt), 64'd1);
    end
    step(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);

    // Last-segment interrupt
    step(1'b1, 4'h4, 32'h3000, 1'b0, 1'b0);
    idle();
    idle();
    step(1'b0, 4'h0, 32'h0, 1'b1, 1'b0);
    idle();
    check("irq_clear", 64'(irq), 64'd0);

    // Flush at level 3 with a concurrent write
    for (int i = 0; i < 3; i++) step(1'b1, 4'h4, 32'h4000 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 4'h4, 32'h4FFF, 1'b1, 1'b1);
    check("clr_cnt", 64'(sts_cnt), 64'd0);
    check("clr_req", 64'(bus_req), 64'd0);
    idle();

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) step(1'b1, 4'h4, $urandom, 1'b0, 1'b0);
    cmd_req = 1'b0; bus_grt = 1'b0;
    #2 rst = 1'b0;
    #1;
    mq.delete();
    irq_m = 1'b0;
    check("async_cnt", 64'(sts_cnt), 64'd0);
    check("async_req", 64'(bus_req), 64'd0);
    check("async_irq", 64'(irq), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compare();
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 2) != 0), 4'($urandom), $urandom,
           1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
